// File: rtl/scan_pkg.sv
// Shared definitions for the scan/direct decoder family.
//   MODE_DIRECT / MODE_SCAN : encodings of the decoder mode input
//   state_t                 : OFF / DIRECT / SCAN operating states
//   onehot()                : index -> one-hot vector, up to 64 lines. Callers
//                             size-cast the result to their own line count.
package scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    function automatic logic [63:0] onehot(input logic [5:0] idx);
        onehot = 64'd1 << idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/blank counter for the scanning decoder.
// One scan slot lasts DWELL + BLANK cycles. The line is shown for the first
// DWELL cycles of the slot and blanked for the remaining BLANK cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the slot counter (takes priority over run)
//   run      : count this cycle
//   adv      : last shown cycle of the line; the index moves on at this edge
//   start    : last cycle of the slot; the next cycle shows a new line
//   blank    : the next cycle falls in the blanking part of the slot
module scan_timer #(
    parameter int DWELL = 1000,
    parameter int BLANK = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic adv,
    output logic start,
    output logic blank
);

    localparam int PERIOD = DWELL + BLANK;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign adv   = run && (cnt_q == DWELL_END);
    assign start = run && (cnt_q == LAST);
    // Next count lands in [DWELL, PERIOD-1]. Empty range when BLANK is 0,
    // because DWELL_END then equals LAST.
    assign blank = run && (cnt_q >= DWELL_END) && (cnt_q != LAST);

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and scanning modes.
// Direct mode shows the latched address. Scan mode walks every line, holding
// each line for DWELL cycles. This drives display digits and keypad columns.
// Build option: SCAN_DECODER_BLANK_EN adds parameter BLANK. When set, each
// scanned line is followed by BLANK all-off cycles (anti-ghosting).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global enable; low turns all lines off
//   mode      : 0 direct, 1 scan
//   sel       : direct-mode address, captured when sel_valid is high
//   sel_valid : address strobe
//   d         : one-hot line outputs (registered)
//   cur_idx   : index shown on d (registered)
//   wrap      : one-cycle pulse on the first line-0 cycle after a wrap
module scan_decoder
    import scan_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int DWELL = 1000
`ifdef SCAN_DECODER_BLANK_EN
    ,
    parameter int BLANK = 2
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic [(1<<SEL_W)-1:0]   d,
    output logic [SEL_W-1:0]        cur_idx,
    output logic                    wrap
);

    localparam int N = 1 << SEL_W;
`ifdef SCAN_DECODER_BLANK_EN
    localparam int BLANK_CYC = BLANK;
`else
    localparam int BLANK_CYC = 0;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] latch_q, latch_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
    logic [N-1:0]     d_q, d_d;
    logic             wrap_q, wrap_d;
    logic             tmr_clr, tmr_run, tmr_adv, tmr_start, tmr_blank;

    scan_timer #(
        .DWELL (DWELL),
        .BLANK (BLANK_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .run   (tmr_run),
        .adv   (tmr_adv),
        .start (tmr_start),
        .blank (tmr_blank)
    );

    always_comb begin
        state_d = ST_OFF;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are computed from the state being entered on this edge, so
    // every input change shows on the registered outputs one cycle later.
    // The direct decode uses latch_d so a strobed address bypasses the latch.
    always_comb begin
        latch_d    = sel_valid ? sel : latch_q;
        scan_idx_d = scan_idx_q;
        cur_idx_d  = cur_idx_q;
        d_d        = '0;
        wrap_d     = 1'b0;
        tmr_clr    = 1'b1;
        tmr_run    = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                d_d       = N'(onehot(6'(latch_d)));
                cur_idx_d = latch_d;
            end
            ST_SCAN: begin
                if (state_q == ST_SCAN) begin
                    tmr_clr = 1'b0;
                    tmr_run = 1'b1;
                    if (tmr_adv) begin
                        scan_idx_d = scan_idx_q + SEL_W'(1);
                    end
                    // Line 0 can only be reached from a running slot by wrapping.
                    wrap_d = tmr_start && (scan_idx_d == '0);
                end else begin
                    scan_idx_d = '0;
                end
                cur_idx_d = scan_idx_d;
                if (!tmr_blank) begin
                    d_d = N'(onehot(6'(scan_idx_d)));
                end
            end
            default: begin
                scan_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q    <= '0;
            scan_idx_q <= '0;
            cur_idx_q  <= '0;
            d_q        <= '0;
            wrap_q     <= 1'b0;
        end else begin
            latch_q    <= latch_d;
            scan_idx_q <= scan_idx_d;
            cur_idx_q  <= cur_idx_d;
            d_q        <= d_d;
            wrap_q     <= wrap_d;
        end
    end

    assign d       = d_q;
    assign cur_idx = cur_idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: two instances (16 lines / DWELL 2, 4 lines / DWELL 3)
// share one stimulus stream and are compared each cycle against an
// arithmetic model of the scan timeline, plus literal directed expectations.
module tb_scan_decoder;

    logic        clk, rst, en, mode, sel_valid;
    logic [3:0]  sel;
    logic [15:0] d4;
    logic [3:0]  cur4;
    logic        wrap4;
    logic [3:0]  d2;
    logic [1:0]  cur2;
    logic        wrap2;

    scan_decoder #(.SEL_W(4), .DWELL(2)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .d(d4), .cur_idx(cur4), .wrap(wrap4)
    );

    scan_decoder #(.SEL_W(2), .DWELL(3)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]),
        .sel_valid(sel_valid), .d(d2), .cur_idx(cur2), .wrap(wrap2)
    );

`ifdef SCAN_DECODER_BLANK_EN
    localparam int BLANK_M  = 2;
    localparam int SCAN_LEN = 21;
`else
    localparam int BLANK_M  = 0;
    localparam int SCAN_LEN = 13;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // ---------------- behavioural model ----------------
    int unsigned n_m  [2] = '{16, 4};
    int unsigned dw_m [2] = '{2, 3};
    int unsigned m_latch [2];
    int unsigned m_k     [2];
    bit          m_scan  [2];
    logic [15:0] m_d     [2];
    int unsigned m_idx   [2];
    bit          m_wrap  [2];

    // Scan output is a pure function of k = cycles since scan entry:
    // slot = k / (DWELL+BLANK), line = slot mod N, shown only in the first
    // DWELL cycles of the slot; a wrap is every N slots (k > 0).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_latch[i] = 0; m_k[i] = 0; m_scan[i] = 0;
                m_d[i] = '0; m_idx[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int unsigned p, line, ph;
                if (sel_valid) m_latch[i] = sel % n_m[i];
                if (!en) begin
                    m_d[i] = '0; m_wrap[i] = 0; m_scan[i] = 0;
                end else if (!mode) begin
                    m_d[i] = 16'(1) << m_latch[i];
                    m_idx[i] = m_latch[i]; m_wrap[i] = 0; m_scan[i] = 0;
                end else begin
                    if (m_scan[i]) m_k[i] = m_k[i] + 1;
                    else begin m_scan[i] = 1; m_k[i] = 0; end
                    p    = dw_m[i] + BLANK_M;
                    line = (m_k[i] / p) % n_m[i];
                    ph   = m_k[i] % p;
                    m_d[i]   = (ph < dw_m[i]) ? (16'(1) << line) : 16'h0;
                    m_idx[i] = (ph < dw_m[i]) ? line : (line + 1) % n_m[i];
                    m_wrap[i] = (m_k[i] > 0) && (m_k[i] % (p * n_m[i]) == 0);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!rst) begin
            chk("u4.d",       64'(d4),    64'(m_d[0]));
            chk("u4.cur_idx", 64'(cur4),  64'(m_idx[0]));
            chk("u4.wrap",    64'(wrap4), 64'(m_wrap[0]));
            chk("u2.d",       64'(d2),    64'(m_d[1]));
            chk("u2.cur_idx", 64'(cur2),  64'(m_idx[1]));
            chk("u2.wrap",    64'(wrap2), 64'(m_wrap[1]));
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, check the model.
    task automatic step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    logic [3:0] scan_tab [SCAN_LEN];

    initial begin
`ifdef SCAN_DECODER_BLANK_EN
        scan_tab = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                     4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1};
`else
        scan_tab = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                     4'h8, 4'h8, 4'h8, 4'h1};
`endif
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; sel_valid = 1'b0;
        repeat (3) step();
        chk("reset.d4", 64'(d4), 64'h0);
        chk("reset.cur4", 64'(cur4), 64'h0);
        chk("reset.wrap4", 64'(wrap4), 64'h0);
        rst = 1'b0;
        step();
        chk("off.d4", 64'(d4), 64'h0);

        // Direct decode: strobe at cycle t, visible at t+1, held afterwards.
        en = 1'b1; mode = 1'b0; sel = 4'd9; sel_valid = 1'b1;
        step();
        chk("direct.d4", 64'(d4), 64'h0200);
        chk("direct.cur4", 64'(cur4), 64'd9);
        sel_valid = 1'b0; sel = 4'd5;
        repeat (2) step();
        chk("direct_hold.d4", 64'(d4), 64'h0200);
        chk("direct_hold.cur4", 64'(cur4), 64'd9);

        // Scan timeline on the 4-line instance.
        mode = 1'b1;
        for (int k = 0; k < SCAN_LEN; k++) begin
            step();
            chk("scan_seq.d2", 64'(d2), 64'(scan_tab[k]));
            chk("scan_seq.wrap2", 64'(wrap2), (k == SCAN_LEN - 1) ? 64'd1 : 64'd0);
        end

        // Disable mid-dwell, then re-enable: restart at line 0, no wrap.
        begin
            int cnt = 0;
            while (d2 !== 4'b0100 && cnt < 60) begin step(); cnt++; end
            chk("wait_0100.d2", 64'(d2), 64'h4);
        end
        en = 1'b0;
        step();
        chk("disable.d2", 64'(d2), 64'h0);
        en = 1'b1;
        step();
        chk("reenable.d2", 64'(d2), 64'h1);
        chk("reenable.wrap2", 64'(wrap2), 64'h0);

        // Address strobed during scan is the one shown after switching to direct.
        sel = 4'd2; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0; mode = 1'b0;
        step();
        chk("to_direct.d2", 64'(d2), 64'h4);
        chk("to_direct.cur2", 64'(cur2), 64'd2);
        chk("to_direct.d4", 64'(d4), 64'h0004);
        mode = 1'b1;
        step();
        chk("to_scan.d2", 64'(d2), 64'h1);
        chk("to_scan.cur2", 64'(cur2), 64'd0);

        // Asynchronous reset while line 6 is lit on the 16-line instance.
        begin
            int cnt = 0;
            while (d4 !== 16'h0040 && cnt < 120) begin step(); cnt++; end
            chk("wait_0040.d4", 64'(d4), 64'h0040);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst.d4", 64'(d4), 64'h0);
        chk("async_rst.cur4", 64'(cur4), 64'h0);
        chk("async_rst.wrap4", 64'(wrap4), 64'h0);
        en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        chk("post_rst.d4", 64'(d4), 64'h0);
        chk("post_rst.d2", 64'(d2), 64'h0);

        // Randomized traffic: mostly enabled, occasional mode flips and strobes.
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            sel_valid = ($urandom_range(0, 3) == 0);
            sel       = 4'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered one-hot decoder: SEL_W select bits drive 2^SEL_W output lines.
- Direct mode decodes a latched address, accepted through a valid strobe.
- Scan mode steps an internal index through every line, holding each line for DWELL cycles. It drives multiplexed display digits and keypad column strobes in the final-project top level.
- Successor to the fixed 4-to-16 enable-cascade decoder: adds parameter width, registered outputs and scanning.

Parameters:
- SEL_W, 4, select width; N = 2^SEL_W output lines. Legal range 1..6.
- DWELL, 1000, clock cycles each line stays asserted in scan mode. Must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  global enable; low forces all lines off
- mode  in  1  0 = direct, 1 = scan
- sel  in  SEL_W  direct-mode address
- sel_valid  in  1  strobe; sel is captured on the edge where this is high
- d  out  N  one-hot line outputs; d[k] high selects line k
- cur_idx  out  SEL_W  index currently asserted on d (registered, matches d)
- wrap  out  1  one-cycle pulse when scan wraps from line N-1 to line 0

Behaviour:
- Reset (async assert, sync release):
  - d = 0, cur_idx = 0, wrap = 0.
  - Address latch = 0, dwell counter = 0.
  - State = OFF.
- States:
  - OFF: en = 0.
  - DIRECT: en = 1, mode = 0.
  - SCAN: en = 1, mode = 1.
  - State is re-evaluated every edge from en and mode.
- All outputs are registered; every output change is visible the cycle after the causing input.
- Address latch:
  - Loads sel on any edge with sel_valid = 1, in all states except reset.
  - Holds otherwise.
- OFF:
  - d = 0, wrap = 0.
  - Dwell counter and scan index cleared to 0.
  - cur_idx holds its last value.
- DIRECT:
  - d = one-hot(latch).
  - A sel_valid in cycle t produces one-hot(new sel) on d in cycle t+1. There is no extra cycle through the latch.
  - cur_idx equals the decoded value.
  - wrap = 0.
- SCAN:
  - Entry (from OFF or DIRECT) in cycle t: index 0 and counter 0; d = one-hot(0) from cycle t+1.
  - Each line is held exactly DWELL cycles, then the index increments.
  - After line N-1 the index wraps to 0. wrap is high for exactly the first cycle that d = one-hot(0) after a wrap.
  - No wrap pulse on initial entry.
  - DWELL = 1: line advances every cycle; wrap fires every N cycles.
- Mode change SCAN→DIRECT: next cycle d = one-hot(latch). A sel_valid during scan updates the latch, and that value is the one shown.
- en falling mid-dwell: d = 0 next cycle. The scan restarts at index 0 when re-enabled.
- Simultaneous sel_valid and a mode change to DIRECT in the same cycle: the new sel is decoded in the following cycle.
- d is never multi-hot; it is either all-zero or exactly one bit.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_EN
- Defined:
  - Adds parameter BLANK (default 2).
  - In SCAN, after each line's DWELL cycles, d = 0 for BLANK cycles before the next line asserts (anti-ghosting).
  - cur_idx already shows the next index during blanking.
  - wrap fires on the first cycle d = one-hot(0) after blanking.
  - Direct mode is unaffected.
- Undefined: no blanking; lines switch back-to-back exactly as above.

Decomposition:
- Shared package scan_pkg:
  - Mode encodings MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1.
  - State encodings ST_OFF, ST_DIRECT, ST_SCAN.
  - A onehot function (index → N-bit vector) reused by other decoders.
- One sub-module, scan_timer: parametrised dwell/blank counter with clear, producing an advance pulse and a blank flag.

Test Plan:
- Reset: assert rst mid-scan with d = 16'h0040 → d = 0, cur_idx = 0, wrap = 0 immediately (asynchronously); after release with en = 0, d stays 0.
- Direct: SEL_W = 4, en = 1, mode = 0, sel = 9 with sel_valid pulse at cycle t → d = 16'h0200 and cur_idx = 9 at t+1, held after sel changes without valid.
- Scan: DWELL = 3, SEL_W = 2, enter scan at cycle t → d = 0001 for t+1..t+3, 0010 for t+4..t+6, 0100, then 1000; d = 0001 with wrap = 1 at t+13 only.
- Disable mid-dwell: en drops while d = 0100 → d = 0 next cycle; re-enable → d = 0001 with no wrap pulse.
- Mode switch: sel = 2 accepted during scan, then mode → 0 → d = 0100 next cycle; back to mode 1 → restart at index 0.
- SCAN_DECODER_BLANK_EN with BLANK = 2, DWELL = 3 → each line 3 cycles on, then 2 cycles d = 0; wrap aligns with the first d = 0001 after blanking.
